// File: rtl/uart_tx_frame.sv
// uart_tx_frame: latches a byte on Data_valid and shifts out one UART frame
// (start, data LSB first, optional parity, stop) at one bit per clk cycle.
`default_nettype none

module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_valid,
  input  logic                  PAR_EN,
  input  logic                  par_bit,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int                c_cnt_w = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [c_cnt_w-1:0]    cnt_q,   cnt_d;
  logic                  par_q,   par_d;
  logic                  paren_q, paren_d;
  logic                  tx_q,    tx_d;
  logic                  busy_q,  busy_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      paren_q <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      paren_q <= paren_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    paren_d = paren_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (Data_valid) begin
          shift_d = P_DATA;
          paren_d = PAR_EN;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        // parity_calc updated par_bit on the accepting edge; freeze it for this frame
        par_d   = par_bit;
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
        cnt_d   = '0;
        state_d = DATA;
      end
      DATA: begin
        if (cnt_q == c_last) begin
          if (paren_q) begin
            tx_d    = par_q;
            state_d = PARITY;
          end else begin
            tx_d    = 1'b1;
            state_d = STOP;
          end
        end else begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + c_cnt_w'(1);
        end
      end
      PARITY: begin
        tx_d    = 1'b1;
        state_d = STOP;
      end
      STOP: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed frame checks with a behavioural parity_calc stand-in.
`default_nettype none

module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic       Data_valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       par_bit;
  logic       TX_OUT;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // registered parity, recomputed on every strobe (even: XOR, odd: XNOR)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            par_bit <= 1'b0;
    else if (Data_valid) par_bit <= PAR_TYP ? ~(^P_DATA) : (^P_DATA);
  end

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .P_DATA    (P_DATA),
    .Data_valid(Data_valid),
    .PAR_EN    (PAR_EN),
    .par_bit   (par_bit),
    .TX_OUT    (TX_OUT),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Requests a frame at the next edge, then checks every line bit, busy,
  // and the idle bit that follows. inj>0 pulses a 0xFF strobe before edge k+inj.
  task automatic send_check(input string name, input logic [7:0] d,
                            input logic pen, input logic ptyp, input int inj);
    logic [10:0] exp_bits;
    logic        par;
    int          nb;
    par = ptyp ? ~(^d) : (^d);
    nb  = pen ? 11 : 10;
    exp_bits = '1;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[1+i] = d[i];
    if (pen) exp_bits[9] = par;
    @(negedge clk);
    P_DATA = d; PAR_EN = pen; PAR_TYP = ptyp; Data_valid = 1'b1;
    for (int j = 0; j < nb; j++) begin
      @(posedge clk); #1;
      check($sformatf("%s tx bit%0d", name, j), {31'd0, TX_OUT}, {31'd0, exp_bits[j]});
      check($sformatf("%s busy bit%0d", name, j), {31'd0, busy}, 32'd1);
      @(negedge clk);
      Data_valid = 1'b0;
      P_DATA = ~d; PAR_EN = ~pen;
      if (inj > 0 && j + 1 == inj) begin
        Data_valid = 1'b1; P_DATA = 8'hFF;
      end
    end
    PAR_EN = pen;
    @(posedge clk); #1;
    check({name, " idle tx"},   {31'd0, TX_OUT}, 32'd1);
    check({name, " idle busy"}, {31'd0, busy},   32'd0);
  endtask

  initial begin
    #12;
    check("reset tx",   {31'd0, TX_OUT}, 32'd1);
    check("reset busy", {31'd0, busy},   32'd0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);

    send_check("A5 even", 8'hA5, 1'b1, 1'b0, 0);
    send_check("A5 odd",  8'hA5, 1'b1, 1'b1, 0);
    send_check("01 nopar", 8'h01, 1'b0, 1'b0, 0);
    repeat (3) begin
      @(posedge clk); #1;
      check("01 stays idle", {31'd0, TX_OUT}, 32'd1);
    end

    send_check("3C inject", 8'h3C, 1'b1, 1'b0, 4);

    // reset mid-frame at k+5
    @(negedge clk);
    P_DATA = 8'hC3; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); Data_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1; check("pre-reset busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("async rst tx",   {31'd0, TX_OUT}, 32'd1);
    check("async rst busy", {31'd0, busy},   32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_check("81 after rst", 8'h81, 1'b1, 1'b0, 0);

    send_check("55 b2b", 8'h55, 1'b1, 1'b0, 0);
    send_check("AA b2b", 8'hAA, 1'b1, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_frame.md
# uart_tx_frame

Frame sequencer and serializer for the UART transmit path. Accepts a byte on a `Data_valid` strobe and latches it along with the parity enable. It then shifts out one frame on `TX_OUT`, one bit per `clk` cycle: start bit, data LSB first, optional parity, stop bit. It sits directly downstream of `parity_calc`, consumes its registered `par_bit`, and receives the same `P_DATA`/`Data_valid` strobe.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame. Must match `parity_calc`, which is fixed at 8.
- `clk`  in  1: bit clock; one `TX_OUT` bit per cycle.
- `rst`  in  1: reset, asynchronous, active-low.
- `P_DATA`  in  DATA_WIDTH: byte to send; sampled only on acceptance.
- `Data_valid`  in  1: request strobe; accepted only in IDLE.
- `PAR_EN`  in  1: 1 = insert parity bit; sampled on acceptance.
- `par_bit`  in  1: parity bit from `parity_calc`; valid from the edge after acceptance.
- `TX_OUT`  out  1: serial line, registered, idles high.
- `busy`  out  1: registered; high from acceptance until the frame ends.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Encoding is free.
- Reset (async, `rst`=0): state=IDLE, `TX_OUT`=1, `busy`=0, bit counter=0, data/parity/enable registers=0. Takes effect immediately, including mid-frame.
- IDLE:
  - `TX_OUT`=1, `busy`=0.
  - On `Data_valid`=1 at an edge: latch `P_DATA` into the shift register and latch `PAR_EN`. Go to START, drive `TX_OUT`<=0, `busy`<=1.
- START, one cycle:
  - Capture `par_bit` into an internal parity register. This isolates the frame from later `par_bit` changes.
  - Drive `TX_OUT`<=data[0], counter<=0, go to DATA.
- DATA, DATA_WIDTH cycles:
  - Each edge shifts right and increments the counter.
  - Bits are driven LSB first.
  - At the edge where counter = DATA_WIDTH-1, go to PARITY if the latched `PAR_EN`=1 (drive `TX_OUT`<=parity register). Otherwise go to STOP (drive `TX_OUT`<=1).
- PARITY, one cycle: drive `TX_OUT`<=1, go to STOP.
- STOP, one cycle: go to IDLE, `busy`<=0, `TX_OUT` stays 1.
- `Data_valid` while `busy`=1 is ignored. `P_DATA`, `PAR_EN` and `par_bit` changes mid-frame have no effect.
- Counter width: clog2(DATA_WIDTH). No wrap occurs because the DATA exit happens at DATA_WIDTH-1.

## Timing
Let k be the accepting edge.
- `TX_OUT` sequence:
  - start bit (0) from edge k
  - D[0]..D[7] from edges k+1..k+8
  - parity from k+9 (when enabled)
  - stop bit (1) from k+10 with parity, or k+9 without
- `busy` rises at k and falls at k+11 (parity) or k+10 (no parity).
- Frame length on line: 11 or 10 bit-times.
- Earliest next acceptance: edge k+12 or k+11. This guarantees at least one idle-high bit between frames.
- `par_bit` is sampled at edge k+1. `parity_calc` updates it at edge k, so no extra latency is needed.
- Upstream rule: assert `Data_valid` only while `busy`=0. A violating strobe is dropped here. `parity_calc` will still recompute, but the frame in flight is unaffected because its parity was captured at k+1.

## Test plan
Bench instantiates `parity_calc` + `uart_tx_frame` sharing `P_DATA`/`Data_valid`.
- `P_DATA`=0xA5, `PAR_EN`=1, `PAR_TYP`=0 -> `TX_OUT` 0,1,0,1,0,0,1,0,1,0(parity),1. `busy` high exactly 11 cycles.
- `P_DATA`=0xA5, `PAR_TYP`=1 -> identical frame except parity bit=1.
- `P_DATA`=0x01, `PAR_EN`=0 -> `TX_OUT` 0,1,0,0,0,0,0,0,0,1. `busy` high 10 cycles. Idle afterwards stays 1.
- Accept 0x3C, then pulse `Data_valid` with 0xFF at edge k+4 -> the 0x3C frame completes unchanged, including parity 0 (even); 0xFF is never sent.
- Deassert `rst` at edge k+5 of a frame -> `TX_OUT`=1 and `busy`=0 immediately. After release, a new 0x81 request sends a correct frame.
- Back-to-back: requests asserted as soon as `busy` falls, data 0x55 then 0xAA with parity -> exactly one idle-high bit between frames; both frames correct.
